// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers a left vector and top matrix, then feeds an
// NxN systolic array with diagonal skew. Optional clear: SYSTOLIC_FEED_CLEAR_EN.
module systolic_feeder #(
  parameter int N         = 3,
  parameter int DW        = 16,
  parameter int CLR_CYC   = 3,
  parameter int DRAIN_CYC = 1,
  parameter int AW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [AW-1:0]   wr_row,
  input  logic [AW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            array_reset,
  output logic [DW-1:0]   l_d_o,
  output logic [N*DW-1:0] t_d_o,
  output logic            read
);

  localparam int KN = 2 * N - 1;
  localparam int KW = (KN > 1) ? $clog2(KN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KN - 1);

  localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCW-1:0] D_LAST =
    DCW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  // Parameter sanity is checked at elaboration.
  if (N < 2 || CLR_CYC < 1 || DRAIN_CYC < 0) begin : g_bad_param
    $error("systolic_feeder: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef SYSTOLIC_FEED_CLEAR_EN
    S_CLEAR = 3'd1,
`endif
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [KW-1:0]  k, k_n;
  logic [DCW-1:0] dc, dc_n;

`ifdef SYSTOLIC_FEED_CLEAR_EN
  localparam int CCW = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CCW-1:0] C_LAST = CCW'(CLR_CYC - 1);
  logic [CCW-1:0] cc, cc_n;
`endif

  logic [DW-1:0] l_buf [N];
  logic [DW-1:0] t_buf [N][N];
  logic [DW-1:0] l_nx  [N];
  logic [DW-1:0] t_nx  [N][N];
  logic [DW-1:0] l_q;
  logic [DW-1:0] t_q   [N];

  logic idle_like;
  logic wr_ok;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign wr_ok     = wr_en && idle_like;

  // State and sequence counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      k     <= '0;
      dc    <= '0;
`ifdef SYSTOLIC_FEED_CLEAR_EN
      cc    <= '0;
`endif
    end else begin
      state <= state_n;
      k     <= k_n;
      dc    <= dc_n;
`ifdef SYSTOLIC_FEED_CLEAR_EN
      cc    <= cc_n;
`endif
    end
  end

  // Next-state and next-counter logic.
  always_comb begin
    state_n = state;
    k_n     = k;
    dc_n    = dc;
`ifdef SYSTOLIC_FEED_CLEAR_EN
    cc_n    = cc;
`endif
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
`ifdef SYSTOLIC_FEED_CLEAR_EN
          state_n = S_CLEAR;
          cc_n    = '0;
`else
          state_n = S_FEED;
          k_n     = '0;
`endif
        end
      end
`ifdef SYSTOLIC_FEED_CLEAR_EN
      S_CLEAR: begin
        if (cc == C_LAST) begin
          state_n = S_FEED;
          k_n     = '0;
        end else begin
          cc_n = cc + 1'b1;
        end
      end
`endif
      S_FEED: begin
        if (k == K_LAST) begin
          dc_n    = '0;
          state_n = (DRAIN_CYC == 0) ? S_DONE : S_DRAIN;
        end else begin
          k_n = k + 1'b1;
        end
      end
      S_DRAIN: begin
        if (dc == D_LAST) begin
          state_n = S_DONE;
        end else begin
          dc_n = dc + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Buffer contents after this cycle's write; the bypass lets a write
  // issued together with start reach the very first feed slot.
  // Indices >= N match no slot, so such writes fall away.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      l_nx[i] = l_buf[i];
      if (wr_ok && !wr_sel && wr_col == AW'(i)) begin
        l_nx[i] = wr_data;
      end
    end
    for (int j = 0; j < N; j++) begin
      for (int i = 0; i < N; i++) begin
        t_nx[j][i] = t_buf[j][i];
        if (wr_ok && wr_sel && wr_row == AW'(j) &&
            wr_col == AW'(i)) begin
          t_nx[j][i] = wr_data;
        end
      end
    end
  end

  // Operand buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        l_buf[i] <= '0;
        for (int j = 0; j < N; j++) begin
          t_buf[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        l_buf[i] <= l_nx[i];
        for (int j = 0; j < N; j++) begin
          t_buf[i][j] <= t_nx[i][j];
        end
      end
    end
  end

  // Skewed operand selection for the upcoming cycle; column j lags j.
  always_comb begin
    l_q = '0;
    for (int j = 0; j < N; j++) begin
      t_q[j] = '0;
    end
    if (state_n == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        if (k_n == KW'(i)) begin
          l_q = l_nx[i];
        end
      end
      for (int j = 0; j < N; j++) begin
        for (int i = 0; i < N; i++) begin
          if (k_n == KW'(i + j)) begin
            t_q[j] = t_nx[j][i];
          end
        end
      end
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      read  <= 1'b0;
      l_d_o <= '0;
      t_d_o <= '0;
    end else begin
      busy  <= !(state_n == S_IDLE || state_n == S_DONE);
      done  <= (state_n == S_DONE) && (state != S_DONE);
      read  <= (state_n == S_DONE);
      l_d_o <= l_q;
      for (int j = 0; j < N; j++) begin
        t_d_o[j*DW +: DW] <= t_q[j];
      end
    end
  end

`ifdef SYSTOLIC_FEED_CLEAR_EN
  // Clear strobe covers exactly the CLEAR cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      array_reset <= 1'b0;
    end else begin
      array_reset <= (state_n == S_CLEAR);
    end
  end
`else
  assign array_reset = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed vector bench for systolic_feeder,
// N=3/DRAIN=1 and N=4/DRAIN=0 instances sharing one input bus.
module tb_systolic_feeder;

`ifdef SYSTOLIC_FEED_CLEAR_EN
  localparam int CLR = 3;
`else
  localparam int CLR = 0;
`endif

  typedef struct {
    logic [15:0] l;
    logic [15:0] t0;
    logic [15:0] t1;
    logic [15:0] t2;
    logic        ar;
    logic        rd;
    logic        dn;
    logic        bz;
  } vec_t;

  typedef logic [15:0] row5_t [5];
  typedef logic [15:0] row7_t [7];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [1:0]  wr_row = '0;
  logic [1:0]  wr_col = '0;
  logic [15:0] wr_data = '0;
  logic        start = 1'b0;

  logic        busy_a, done_a, ar_a, read_a;
  logic [15:0] l_a;
  logic [47:0] t_a;
  logic        busy_b, done_b, ar_b, read_b;
  logic [15:0] l_b;
  logic [63:0] t_b;

  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];

  systolic_feeder #(.N(3), .DW(16), .CLR_CYC(3), .DRAIN_CYC(1)) dut_a (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .start(start), .busy(busy_a), .done(done_a),
    .array_reset(ar_a), .l_d_o(l_a), .t_d_o(t_a), .read(read_a)
  );

  systolic_feeder #(.N(4), .DW(16), .CLR_CYC(3), .DRAIN_CYC(0)) dut_b (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .start(start), .busy(busy_b), .done(done_b),
    .array_reset(ar_b), .l_d_o(l_b), .t_d_o(t_b), .read(read_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic sel, input logic [1:0] row,
                    input logic [1:0] col, input logic [15:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = row; wr_col = col; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  function automatic vec_t mkv(input logic [15:0] l, t0, t1, t2,
                               input logic ar, rd, dn, bz);
    vec_t v;
    v.l = l; v.t0 = t0; v.t1 = t1; v.t2 = t2;
    v.ar = ar; v.rd = rd; v.dn = dn; v.bz = bz;
    return v;
  endfunction

  task automatic mk_run(input row5_t lv, t0v, t1v, t2v);
    tbl.delete();
    for (int c = 0; c < CLR; c++)
      tbl.push_back(mkv(0, 0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mkv(lv[k], t0v[k], t1v[k], t2v[k],
                        1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mkv(0, 0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0));
    tbl.push_back(mkv(0, 0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0));
  endtask

  task automatic chk_vec(input vec_t v, input int i);
    chk($sformatf("a.l_d_o@%0d", i), 64'(l_a), 64'(v.l));
    chk($sformatf("a.t0@%0d", i), 64'(t_a[0+:16]), 64'(v.t0));
    chk($sformatf("a.t1@%0d", i), 64'(t_a[16+:16]), 64'(v.t1));
    chk($sformatf("a.t2@%0d", i), 64'(t_a[32+:16]), 64'(v.t2));
    chk($sformatf("a.array_reset@%0d", i), 64'(ar_a), 64'(v.ar));
    chk($sformatf("a.read@%0d", i), 64'(read_a), 64'(v.rd));
    chk($sformatf("a.done@%0d", i), 64'(done_a), 64'(v.dn));
    chk($sformatf("a.busy@%0d", i), 64'(busy_a), 64'(v.bz));
  endtask

  task automatic apply_run();
    start = 1'b1;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      chk_vec(tbl[i], i);
      if (i < tbl.size() - 1) step();
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".a.outs"},
        {8'(busy_a), 8'(done_a), 8'(ar_a), 8'(read_a)}, 0);
    chk({nm, ".a.data"}, {l_a, t_a}, 0);
    chk({nm, ".b.outs"},
        {8'(busy_b), 8'(done_b), 8'(ar_b), 8'(read_b)}, 0);
    chk({nm, ".b.data"}, {l_b, t_b}, 0);
  endtask

  initial begin
    row5_t lv, t0v, t1v, t2v, zv;
    row7_t bt0, bt3;

    step();
    step();
    chk_zero("reset");
    reset = 1'b0;

    // Basic skew run.
    wr(0, 0, 0, 8); wr(0, 0, 1, 10); wr(0, 0, 2, 4);
    wr(1, 0, 0, 1); wr(1, 0, 1, 7); wr(1, 0, 2, 9);
    wr(1, 1, 0, 6); wr(1, 1, 1, 3); wr(1, 1, 2, 5);
    wr(1, 2, 0, 2); wr(1, 2, 1, 7); wr(1, 2, 2, 2);
    lv  = '{16'd8, 16'd10, 16'd4, 16'd0, 16'd0};
    t0v = '{16'd1, 16'd7, 16'd9, 16'd0, 16'd0};
    t1v = '{16'd0, 16'd6, 16'd3, 16'd5, 16'd0};
    t2v = '{16'd0, 16'd0, 16'd2, 16'd7, 16'd2};
    mk_run(lv, t0v, t1v, t2v);
    apply_run();

    // Write during FEED and start during DRAIN are both ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= CLR + 7; i++) begin
      if (i == CLR + 1) begin
        chk("busy.l_k1", 64'(l_a), 64'd10);
        wr_en = 1'b1; wr_sel = 1'b0; wr_col = 2'd0; wr_data = 16'd99;
      end
      if (i == CLR + 2) wr_en = 1'b0;
      if (i == CLR + 5) begin
        chk("busy.drain", 64'(busy_a), 64'd1);
        start = 1'b1;
      end
      if (i == CLR + 6) begin
        start = 1'b0;
        chk("busy.done", {62'd0, done_a, read_a}, 64'd3);
      end
      if (i == CLR + 7)
        chk("busy.after", {61'd0, busy_a, done_a, read_a}, 64'd1);
      if (i < CLR + 7) step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart.read_low", 64'(read_a), 64'd0);
    for (int i = 0; i < CLR; i++) step();
    chk("restart.l_k0", 64'(l_a), 64'd8);

    // Reset at feed k=2.
    step();
    step();
    chk("midrst.l_k2", 64'(l_a), 64'd4);
    chk("midrst.t2_k2", 64'(t_a[32+:16]), 64'd2);
    reset = 1'b1;
    step();
    chk_zero("midrst");
    reset = 1'b0;
    zv = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    mk_run(zv, zv, zv, zv);
    apply_run();

    // Out-of-range writes, then write together with start.
    wr(1, 3, 0, 16'd55);
    wr(0, 0, 3, 16'd77);
    wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd1;
    wr_data = 16'h1234;
    lv = '{16'd0, 16'h1234, 16'd0, 16'd0, 16'd0};
    mk_run(lv, zv, zv, zv);
    apply_run();

    // N=4, no drain.
    reset = 1'b1;
    step();
    reset = 1'b0;
    wr(1, 3, 0, 1); wr(1, 3, 1, 2); wr(1, 3, 2, 3); wr(1, 3, 3, 4);
    wr(1, 0, 3, 5);
    bt3 = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4};
    bt0 = '{16'd0, 16'd0, 16'd0, 16'd5, 16'd0, 16'd0, 16'd0};
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= CLR + 7; i++) begin
      if (i < CLR) begin
        chk($sformatf("b.clear@%0d", i), {62'd0, ar_b, busy_b}, 64'd3);
      end else if (i < CLR + 7) begin
        chk($sformatf("b.t3@k%0d", i - CLR), 64'(t_b[48+:16]),
            64'(bt3[i-CLR]));
        chk($sformatf("b.t0@k%0d", i - CLR), 64'(t_b[0+:16]),
            64'(bt0[i-CLR]));
        chk($sformatf("b.ctl@k%0d", i - CLR),
            {60'd0, ar_b, busy_b, read_b, done_b}, 64'd4);
      end else begin
        chk("b.read", {60'd0, ar_b, busy_b, read_b, done_b}, 64'd3);
      end
      if (i < CLR + 7) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
